// File: rtl/ripple_counter_ctl_if.sv
`default_nettype none
// ==========================================================================
// Module   : ripple_counter_ctl_if
// Brief    : Host controls, counter feedback and status of ripple_counter_ctl.
// Revision : 1.0 - initial release
// ==========================================================================
interface ripple_counter_ctl_if;
  logic       start;
  logic       stop;
  logic [7:0] period;
  logic       oneshot;
  logic       irq_ack;
  logic [7:0] cnt_q;
  logic       cnt_clk_n;
  logic       cnt_reset;
  logic       busy;
  logic       tick;
  logic       irq;
  logic       overrun;
  logic       fault;

  modport master (
    output start, stop, period, oneshot, irq_ack, cnt_q,
    input  cnt_clk_n, cnt_reset, busy, tick, irq, overrun, fault
  );

  modport slave (
    input  start, stop, period, oneshot, irq_ack, cnt_q,
    output cnt_clk_n, cnt_reset, busy, tick, irq, overrun, fault
  );
endinterface
`default_nettype wire

// File: rtl/ripple_counter_ctl.sv
`default_nettype none
// ==========================================================================
// Module   : ripple_counter_ctl
// Brief    : Interval-timer sequencer for two cascaded 4-bit ripple counters.
// Revision : 1.0 - initial release
// ==========================================================================
module ripple_counter_ctl #(
  parameter int DIV = 4
) (
  input  wire logic           CLK,
  input  wire logic           RESET,
  ripple_counter_ctl_if.slave bus
);

  localparam logic [4:0] PRESCALE_LOAD = 5'(DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOW    = 3'd2,
    ST_HIGH   = 3'd3,
    ST_EXPIRE = 3'd4
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] shadow, shadow_nxt;
  logic [7:0] period_lat, period_lat_nxt;
  logic       oneshot_lat, oneshot_lat_nxt;
  logic [4:0] prescale, prescale_nxt;
  logic       cnt_reset_nxt;
  logic       cnt_clk_n_nxt;
  logic       busy_nxt;
  logic       tick_nxt;
  logic       irq_nxt;
  logic       overrun_nxt;
  logic       fault_nxt;

  always_comb begin
    state_nxt       = state;
    shadow_nxt      = shadow;
    period_lat_nxt  = period_lat;
    oneshot_lat_nxt = oneshot_lat;
    prescale_nxt    = prescale;
    fault_nxt       = bus.fault;
    irq_nxt         = bus.irq;
    overrun_nxt     = bus.overrun;

    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.stop && (bus.period != 8'd0)) begin
          state_nxt       = ST_CLEAR;
          period_lat_nxt  = bus.period;
          oneshot_lat_nxt = bus.oneshot;
          fault_nxt       = 1'b0;
        end
      end
      ST_CLEAR:  state_nxt = ST_LOW;
      ST_LOW:    state_nxt = ST_HIGH;
      ST_HIGH: begin
        // Last settle cycle: the rippled count must now match the shadow.
        if (prescale == 5'd1) begin
          if (bus.cnt_q != shadow) begin
            fault_nxt = 1'b1;
            state_nxt = ST_IDLE;
          end else if (shadow == period_lat) begin
            state_nxt = ST_EXPIRE;
          end else begin
            state_nxt = ST_LOW;
          end
        end
      end
      ST_EXPIRE: state_nxt = oneshot_lat ? ST_IDLE : ST_CLEAR;
      default:   state_nxt = ST_IDLE;
    endcase

    // An abort wins over everything, including a pending compare result.
    if (bus.stop) begin
      state_nxt = ST_IDLE;
      fault_nxt = bus.fault;
    end

    case (state_nxt)
      ST_CLEAR: shadow_nxt   = 8'd0;
      ST_LOW:   shadow_nxt   = shadow + 8'd1;
      ST_HIGH:  prescale_nxt = (state == ST_LOW) ? PRESCALE_LOAD : (prescale - 5'd1);
      default:  ;
    endcase

    cnt_reset_nxt = (state_nxt == ST_IDLE) || (state_nxt == ST_CLEAR);
    cnt_clk_n_nxt = (state_nxt != ST_LOW);
    busy_nxt      = (state_nxt != ST_IDLE);
    tick_nxt      = (state_nxt == ST_EXPIRE);

    if (tick_nxt) begin
      irq_nxt = 1'b1;
      if (bus.irq && !bus.irq_ack) begin
        overrun_nxt = 1'b1;
      end else if (bus.irq_ack) begin
        overrun_nxt = 1'b0;
      end
    end else if (bus.irq_ack) begin
      irq_nxt     = 1'b0;
      overrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= ST_IDLE;
      shadow        <= 8'd0;
      period_lat    <= 8'd0;
      oneshot_lat   <= 1'b0;
      prescale      <= 5'd0;
      bus.cnt_reset <= 1'b1;
      bus.cnt_clk_n <= 1'b1;
      bus.busy      <= 1'b0;
      bus.tick      <= 1'b0;
      bus.irq       <= 1'b0;
      bus.overrun   <= 1'b0;
      bus.fault     <= 1'b0;
    end else begin
      state         <= state_nxt;
      shadow        <= shadow_nxt;
      period_lat    <= period_lat_nxt;
      oneshot_lat   <= oneshot_lat_nxt;
      prescale      <= prescale_nxt;
      bus.cnt_reset <= cnt_reset_nxt;
      bus.cnt_clk_n <= cnt_clk_n_nxt;
      bus.busy      <= busy_nxt;
      bus.tick      <= tick_nxt;
      bus.irq       <= irq_nxt;
      bus.overrun   <= overrun_nxt;
      bus.fault     <= fault_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ripple_counter_ctl.sv
`default_nettype none
// ==========================================================================
// Module   : tb_ripple_counter_ctl
// Brief    : Directed bench for ripple_counter_ctl with a two-counter model.
// Revision : 1.0 - initial release
// ==========================================================================
`timescale 1ns/1ps
module tb_ripple_counter_ctl;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  ripple_counter_ctl_if bus4();
  ripple_counter_ctl_if bus2();

  ripple_counter_ctl #(.DIV(4)) dut4 (.CLK(CLK), .RESET(RESET), .bus(bus4));
  ripple_counter_ctl #(.DIV(2)) dut2 (.CLK(CLK), .RESET(RESET), .bus(bus2));

  // Two cascaded 4-bit counters per DUT; the high nibble steps when low QD falls.
  logic [3:0] lo4 = 4'd0, hi4 = 4'd0, lo2 = 4'd0, hi2 = 4'd0;
  logic       prev4 = 1'b1, prev2 = 1'b1;
  logic [7:0] mask4 = 8'hFF;
  int         falls4 = 0;

  assign bus4.cnt_q = {hi4, lo4} & mask4;
  assign bus2.cnt_q = {hi2, lo2};

  always @(negedge CLK) begin
    if (bus4.cnt_reset === 1'b1) begin
      lo4 = 4'd0; hi4 = 4'd0;
    end else if (prev4 && !bus4.cnt_clk_n) begin
      lo4 = lo4 + 4'd1;
      if (lo4 == 4'd0) hi4 = hi4 + 4'd1;
    end
    if (prev4 && !bus4.cnt_clk_n) falls4++;
    prev4 = bus4.cnt_clk_n;

    if (bus2.cnt_reset === 1'b1) begin
      lo2 = 4'd0; hi2 = 4'd0;
    end else if (prev2 && !bus2.cnt_clk_n) begin
      lo2 = lo2 + 4'd1;
      if (lo2 == 4'd0) hi2 = hi2 + 4'd1;
    end
    prev2 = bus2.cnt_clk_n;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge CLK);
    #1;
  endtask

  int         ticks, tick_edge, t1, t2;
  logic       ov1, ov2, irq1, seen_carry;
  logic [7:0] q, prevq, qtick;

  initial begin
    bus4.start = 0; bus4.stop = 0; bus4.period = 0; bus4.oneshot = 0; bus4.irq_ack = 0;
    bus2.start = 0; bus2.stop = 0; bus2.period = 0; bus2.oneshot = 0; bus2.irq_ack = 0;
    #2 RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_cnt_reset", bus4.cnt_reset, 1);
    check("rst_cnt_clk_n", bus4.cnt_clk_n, 1);
    check("rst_busy", bus4.busy, 0);
    check("rst_tick", bus4.tick, 0);
    check("rst_irq", bus4.irq, 0);
    check("rst_overrun", bus4.overrun, 0);
    check("rst_fault", bus4.fault, 0);
    check("rst2_busy", bus2.busy, 0);
    RESET = 1'b0;
    next_edge();

    // One-shot, DIV=4, N=3
    bus4.period = 8'd3; bus4.oneshot = 1; bus4.start = 1; falls4 = 0;
    next_edge();
    bus4.start = 0;
    check("a_clear_busy", bus4.busy, 1);
    check("a_clear_reset", bus4.cnt_reset, 1);
    ticks = 0; tick_edge = -1;
    for (int e = 1; e <= 20; e++) begin
      next_edge();
      if (bus4.tick) begin ticks++; tick_edge = e; end
      if (e == 13) begin
        check("a_irq", bus4.irq, 1);
        check("a_q", bus4.cnt_q, 8'd3);
        check("a_busy13", bus4.busy, 1);
      end
      if (e == 14) check("a_busy14", bus4.busy, 0);
    end
    check("a_ticks", ticks, 1);
    check("a_tick_edge", tick_edge, 13);
    check("a_falls", falls4, 3);
    check("a_fault", bus4.fault, 0);
    bus4.irq_ack = 1;
    next_edge();
    bus4.irq_ack = 0;
    check("a_ack_irq", bus4.irq, 0);

    // Auto-reload with overrun, DIV=2, N=5; mid-run PERIOD/ONESHOT edits must be ignored
    bus2.period = 8'd5; bus2.oneshot = 0; bus2.start = 1;
    next_edge();
    bus2.start = 0; bus2.period = 8'd1; bus2.oneshot = 1;
    t1 = -1; t2 = -1; ov1 = 0; ov2 = 0; irq1 = 0;
    for (int e = 1; e <= 40; e++) begin
      next_edge();
      if (bus2.tick) begin
        if (t1 < 0) begin t1 = e; ov1 = bus2.overrun; irq1 = bus2.irq; end
        else if (t2 < 0) begin t2 = e; ov2 = bus2.overrun; end
      end
    end
    check("b_t1", t1, 11);
    check("b_interval", t2 - t1, 12);
    check("b_irq1", irq1, 1);
    check("b_ov1", ov1, 0);
    check("b_ov2", ov2, 1);
    bus2.irq_ack = 1;
    next_edge();
    bus2.irq_ack = 0;
    check("b_ack_irq", bus2.irq, 0);
    check("b_ack_overrun", bus2.overrun, 0);
    check("b_still_busy", bus2.busy, 1);
    bus2.stop = 1;
    next_edge();
    bus2.stop = 0;
    check("b_stop_busy", bus2.busy, 0);

    // Carry ripple, DIV=4, N=255
    bus4.period = 8'd255; bus4.oneshot = 1; bus4.start = 1;
    next_edge();
    bus4.start = 0;
    ticks = 0; tick_edge = -1; prevq = 8'd0; seen_carry = 0; qtick = 8'd0;
    for (int e = 1; e <= 1030; e++) begin
      next_edge();
      q = bus4.cnt_q;
      if (prevq == 8'h0F && q == 8'h10) seen_carry = 1;
      prevq = q;
      if (bus4.tick) begin ticks++; tick_edge = e; qtick = q; end
    end
    check("c_carry", seen_carry, 1);
    check("c_tick_edge", tick_edge, 1021);
    check("c_ticks", ticks, 1);
    check("c_qtick", qtick, 8'hFF);
    check("c_fault", bus4.fault, 0);

    // Fault: bit 4 stuck low, N=20
    mask4 = 8'hEF; bus4.period = 8'd20; bus4.start = 1;
    next_edge();
    bus4.start = 0;
    ticks = 0;
    for (int e = 1; e <= 70; e++) begin
      next_edge();
      if (bus4.tick) ticks++;
      if (e == 64) check("d_fault64", bus4.fault, 0);
      if (e == 65) begin
        check("d_fault65", bus4.fault, 1);
        check("d_busy65", bus4.busy, 0);
      end
    end
    check("d_no_tick", ticks, 0);
    mask4 = 8'hFF; bus4.period = 8'd1; bus4.start = 1;
    next_edge();
    bus4.start = 0;
    check("d_fault_clr", bus4.fault, 0);
    check("d_restart_busy", bus4.busy, 1);
    repeat (10) next_edge();

    // Abort on the S==N compare cycle, DIV=4, N=2
    bus4.period = 8'd2; bus4.start = 1;
    next_edge();
    bus4.start = 0;
    repeat (8) next_edge();
    bus4.stop = 1;
    next_edge();
    bus4.stop = 0;
    check("e_tick", bus4.tick, 0);
    check("e_busy", bus4.busy, 0);
    check("e_cnt_reset", bus4.cnt_reset, 1);
    ticks = 0;
    for (int e = 0; e < 5; e++) begin
      next_edge();
      if (bus4.tick) ticks++;
    end
    check("e_no_tick", ticks, 0);
    bus4.start = 1; bus4.stop = 1;
    next_edge();
    bus4.start = 0; bus4.stop = 0;
    check("e_start_stop", bus4.busy, 0);

    // Reset mid-HIGH, then START with PERIOD=0
    bus4.period = 8'd10; bus4.start = 1;
    next_edge();
    bus4.start = 0;
    repeat (2) next_edge();
    check("f_pre_irq", bus4.irq, 1);
    #2 RESET = 1'b1;
    #1;
    check("f_cnt_reset", bus4.cnt_reset, 1);
    check("f_cnt_clk_n", bus4.cnt_clk_n, 1);
    check("f_busy", bus4.busy, 0);
    check("f_tick", bus4.tick, 0);
    check("f_irq", bus4.irq, 0);
    check("f_overrun", bus4.overrun, 0);
    check("f_fault", bus4.fault, 0);
    @(negedge CLK);
    RESET = 1'b0;
    next_edge();
    bus4.period = 8'd0; bus4.start = 1;
    next_edge();
    bus4.start = 0;
    check("f_p0_busy", bus4.busy, 0);
    next_edge();
    check("f_p0_busy2", bus4.busy, 0);
    check("f_p0_cnt_reset", bus4.cnt_reset, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
